// File: rtl/ssp_param.sv
// ssp_param: parametrised synchronous serial port with TX/RX FIFOs,
// generated serial clock, framed MSB-first shifting and internal loopback.

// Small occupancy-tracked FIFO. The head is read combinationally so a consumer
// can pop and load the word on the same edge.
module ssp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_head,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  // A push into a full FIFO still lands when the same cycle frees an entry.
  assign w_push_ok = i_push & (~o_full | i_pop);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rptr];
  assign o_level   = r_level;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push_ok) - LW'(w_pop_ok);
    end
  end
endmodule

module ssp_param #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2,
  parameter int LW      = $clog2(DEPTH + 1)
) (
  input  logic              pclk,
  input  logic              clear_b,
  input  logic              psel,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  input  logic              loopback,
  input  logic              sspclkin,
  input  logic              sspfssin,
  input  logic              ssprxd,
  output logic              sspclkout,
  output logic              sspfssout,
  output logic              ssptxd,
  output logic              sspoe_b,
  output logic              ssptxintr,
  output logic              ssprxintr,
  output logic [LW-1:0]     tx_level,
  output logic [LW-1:0]     rx_level,
  output logic              rx_ovr
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [1:0] {T_IDLE, T_SYNC, T_SHIFT} tx_state_t;
  typedef enum logic {R_IDLE, R_SHIFT} rx_state_t;

  logic [CW-1:0]     r_div_cnt;
  logic              r_sclk;
  tx_state_t         r_tx_st;
  logic [DATA_W-1:0] r_tx_sh;
  logic [BW-1:0]     r_tx_cnt;
  logic              r_fss;
  logic              r_txd;
  logic              r_oe_b;
  rx_state_t         r_rx_st;
  logic [DATA_W-1:0] r_rx_sh;
  logic [BW-1:0]     r_rx_cnt;
  logic              r_rx_push;
  logic              r_ck_s1, r_ck_s2, r_fs_s1, r_fs_s2, r_dt_s1, r_dt_s2;
  logic              r_ck_d;
  logic [DATA_W-1:0] r_prdata;
  logic              r_ovr;

  logic              w_tick, w_bnd, w_tx_pop;
  logic              w_wr, w_rd;
  logic [DATA_W-1:0] w_tx_head, w_rx_head;
  logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic              w_src_ck, w_src_fs, w_src_dt, w_rise;

  assign w_tick = (r_div_cnt == CW'(CLK_DIV - 1));
  // Bit boundary: the edge on which sspclkout falls.
  assign w_bnd  = w_tick & r_sclk;
  assign w_wr   = psel & pwrite;
  assign w_rd   = psel & ~pwrite;

  // TX FIFO is popped whenever the shifter is free at a bit boundary.
  always_comb begin
    w_tx_pop = 1'b0;
    if (w_bnd && !w_tx_empty) begin
      if (r_tx_st == T_IDLE) w_tx_pop = 1'b1;
      if (r_tx_st == T_SHIFT && r_tx_cnt == BW'(DATA_W - 1)) w_tx_pop = 1'b1;
    end
  end

  ssp_fifo #(.W(DATA_W), .DEPTH(DEPTH), .LW(LW)) u_tx_fifo (
    .clk(pclk), .rst_n(clear_b), .i_push(w_wr), .i_pop(w_tx_pop),
    .i_din(pwdata), .o_head(w_tx_head), .o_level(tx_level),
    .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  ssp_fifo #(.W(DATA_W), .DEPTH(DEPTH), .LW(LW)) u_rx_fifo (
    .clk(pclk), .rst_n(clear_b), .i_push(r_rx_push), .i_pop(w_rd),
    .i_din(r_rx_sh), .o_head(w_rx_head), .o_level(rx_level),
    .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  // Free-running divider: sspclkout toggles every CLK_DIV cycles, low half first.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  // TX framer: one sync bit period, then DATA_W data bits MSB-first.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_tx_st  <= T_IDLE;
      r_tx_sh  <= '0;
      r_tx_cnt <= '0;
      r_fss    <= 1'b0;
      r_txd    <= 1'b0;
      r_oe_b   <= 1'b1;
    end else if (w_bnd) begin
      case (r_tx_st)
        T_IDLE: begin
          if (!w_tx_empty) begin
            r_tx_sh <= w_tx_head;
            r_fss   <= 1'b1;
            r_tx_st <= T_SYNC;
          end
        end
        T_SYNC: begin
          r_fss    <= 1'b0;
          r_txd    <= r_tx_sh[DATA_W-1];
          r_oe_b   <= 1'b0;
          r_tx_cnt <= '0;
          r_tx_st  <= T_SHIFT;
        end
        T_SHIFT: begin
          if (r_tx_cnt == BW'(DATA_W - 1)) begin
            r_txd    <= 1'b0;
            r_oe_b   <= 1'b1;
            r_tx_cnt <= '0;
            // Back-to-back frames: the last boundary may start the next sync.
            if (!w_tx_empty) begin
              r_tx_sh <= w_tx_head;
              r_fss   <= 1'b1;
              r_tx_st <= T_SYNC;
            end else begin
              r_tx_st <= T_IDLE;
            end
          end else begin
            r_tx_sh  <= r_tx_sh << 1;
            r_txd    <= r_tx_sh[DATA_W-2];
            r_tx_cnt <= r_tx_cnt + BW'(1);
          end
        end
        default: r_tx_st <= T_IDLE;
      endcase
    end
  end

  // Two-flop synchronisers for the external receive pins plus edge history.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      {r_ck_s1, r_ck_s2, r_fs_s1, r_fs_s2, r_dt_s1, r_dt_s2} <= '0;
      r_ck_d <= 1'b0;
    end else begin
      r_ck_s1 <= sspclkin;
      r_ck_s2 <= r_ck_s1;
      r_fs_s1 <= sspfssin;
      r_fs_s2 <= r_fs_s1;
      r_dt_s1 <= ssprxd;
      r_dt_s2 <= r_dt_s1;
      r_ck_d  <= w_src_ck;
    end
  end

  // Loopback taps the already-registered TX outputs, so no synchroniser is needed.
  assign w_src_ck = loopback ? r_sclk : r_ck_s2;
  assign w_src_fs = loopback ? r_fss  : r_fs_s2;
  assign w_src_dt = loopback ? r_txd  : r_dt_s2;
  assign w_rise   = w_src_ck & ~r_ck_d;

  // RX deframer: wait for frame sync, then gather DATA_W bits; push one cycle later.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_rx_st   <= R_IDLE;
      r_rx_sh   <= '0;
      r_rx_cnt  <= '0;
      r_rx_push <= 1'b0;
    end else begin
      r_rx_push <= 1'b0;
      if (w_rise) begin
        case (r_rx_st)
          R_IDLE: begin
            if (w_src_fs) begin
              r_rx_cnt <= '0;
              r_rx_st  <= R_SHIFT;
            end
          end
          R_SHIFT: begin
            r_rx_sh  <= {r_rx_sh[DATA_W-2:0], w_src_dt};
            r_rx_cnt <= r_rx_cnt + BW'(1);
            if (r_rx_cnt == BW'(DATA_W - 1)) begin
              r_rx_push <= 1'b1;
              r_rx_st   <= R_IDLE;
            end
          end
          default: r_rx_st <= R_IDLE;
        endcase
      end
    end
  end

  // Read data register and sticky overrun flag.
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      r_prdata <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_rd && !w_rx_empty) r_prdata <= w_rx_head;
      if (r_rx_push && w_rx_full && !w_rd) r_ovr <= 1'b1;
      else if (w_rd && w_rx_empty)         r_ovr <= 1'b0;
    end
  end

  assign prdata    = r_prdata;
  assign rx_ovr    = r_ovr;
  assign sspclkout = r_sclk;
  assign sspfssout = r_fss;
  assign ssptxd    = r_txd;
  assign sspoe_b   = r_oe_b;
  assign ssptxintr = w_tx_full;
  assign ssprxintr = w_rx_full;
endmodule
